// File: rtl/multicycle_control.sv
// Multicycle control FSM: steps the shared MIPS datapath through fetch/decode/execute/memory/writeback.
// Latency: zero-wait memory FETCH->FETCH is 3 (beq/blt/j), 4 (R/addi/subi/sw), 5 (lw) cycles; each wait cycle adds one.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready; a stall of MAX_WAIT cycles traps with sticky bus_err.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   op, zero, lt          opcode from IR, ALU zero / signed less-than flags
//   mem_ready             memory completes the current access this cycle
//   pc_write .. mem_write datapath enables
//   iord .. pc_source     datapath mux selects
//   aluop1, aluop2        ALU mode to the ALU control decoder (00 add, 01 sub, 10 funct)
//   state, illegal        current state code, high in TRAP
//   bus_err, instr_count  sticky watchdog error, retired-instruction counter (wraps)
module multicycle_control #(
  parameter int COUNT_W  = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               lt,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic               aluop1,
  output logic               aluop2,
  output logic [3:0]         state,
  output logic               illegal,
  output logic               bus_err,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_REXEC  = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_IEXEC  = 4'd8;
  localparam logic [3:0] S_IWB    = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BLT  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SUBI = 6'd9;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  // The counter only ever has to hold MAX_WAIT-1: the stall cycle that would
  // bring it to MAX_WAIT is the expiry cycle and leaves the wait state.
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  logic [3:0]        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              expire;
  logic              retire;

  assign waiting = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign expire  = (MAX_WAIT != 0) && waiting && !mem_ready &&
                   (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  always_comb begin
    state_nxt  = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    aluop1     = 1'b0;
    aluop2     = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW:     state_nxt = S_MEMADR;
          OP_R:             state_nxt = S_REXEC;
          OP_ADDI, OP_SUBI: state_nxt = S_IEXEC;
          OP_BEQ, OP_BLT:   state_nxt = S_BRANCH;
          OP_J:             state_nxt = S_JUMP;
          default:          state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (op == OP_LW)      state_nxt = S_MEMRD;
        else if (op == OP_SW) state_nxt = S_MEMWR;
        else                  state_nxt = S_TRAP;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        aluop1    = 1'b1;
        state_nxt = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aluop2    = (op == OP_SUBI);
        state_nxt = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluop2    = 1'b1;
        pc_source = 2'b01;
        pc_write  = ((op == OP_BEQ) && zero) || ((op == OP_BLT) && lt);
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_nxt = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        // Unused codes 13..15 can only come from an upset; park safely.
        state_nxt = S_TRAP;
      end
    endcase

    // Watchdog expiry overrides the normal decode: drop every enable so the
    // stalled access is abandoned without side effects.
    if (expire) begin
      state_nxt = S_TRAP;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  // Not-taken branches retire too; MEMWR retires only on the completing cycle.
  assign retire = (state_nxt == S_FETCH) &&
                  ((state == S_MEMWB) || (state == S_MEMWR) || (state == S_RWB) ||
                   (state == S_IWB) || (state == S_BRANCH) || (state == S_JUMP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      instr_count <= '0;
      bus_err     <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (retire) instr_count <= instr_count + COUNT_W'(1);
      if (expire) bus_err <= 1'b1;
      // Clearing on any state change covers entry to FETCH, MEMRD and MEMWR.
      if (state_nxt != state)         wait_cnt <= '0;
      else if (waiting && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: driver pushes per-cycle expectations, negedge monitor pops and compares.
// Uses COUNT_W=4 so the retired-instruction counter wraps during the random phase, MAX_WAIT=4 for the watchdog.
// Expected state sequences come from the per-opcode cycle counts; expected controls from the state output table.
module tb_multicycle_control;

  localparam int CW = 4;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    op;
  logic          zero, lt, mem_ready;
  logic          pc_write, ir_write, reg_write, mem_read, mem_write;
  logic          iord, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]    alu_src_b, pc_source;
  logic          aluop1, aluop2, illegal, bus_err;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;
  logic [17:0]   ctrl_vec;

  typedef struct {
    logic [3:0]    st;
    logic [17:0]   ctrl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  logic [CW-1:0] exp_cnt;
  logic          exp_berr;
  int            n_chk  = 0;
  int            n_fail = 0;

  multicycle_control #(.COUNT_W(CW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .lt(lt), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .aluop1(aluop1), .aluop2(aluop2), .state(state),
    .illegal(illegal), .bus_err(bus_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign ctrl_vec = {pc_write, ir_write, reg_write, mem_read, mem_write, iord, reg_dst,
                     mem_to_reg, alu_src_a, alu_src_b, pc_source, aluop1, aluop2,
                     illegal, bus_err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Output table by state; x marks the watchdog expiry cycle.
  function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic [5:0] o,
                                           input logic z, input logic l, input logic rdy,
                                           input logic x, input logic be);
    logic pcw, irw, rw, mr, mwr, io, rd, m2r, asa, a1, a2, ill;
    logic [1:0] asb, pcs;
    {pcw, irw, rw, mr, mwr, io, rd, m2r, asa, a1, a2, ill} = '0;
    asb = 2'b00;
    pcs = 2'b00;
    case (st)
      4'd0:  begin mr = !x; asb = 2'b01; pcw = rdy && !x; irw = rdy && !x; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  begin mr = !x; io = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin mwr = !x; io = 1'b1; end
      4'd6:  begin asa = 1'b1; a1 = 1'b1; end
      4'd7:  begin rw = 1'b1; rd = 1'b1; end
      4'd8:  begin asa = 1'b1; asb = 2'b10; a2 = (o == 6'd9); end
      4'd9:  rw = 1'b1;
      4'd10: begin asa = 1'b1; a2 = 1'b1; pcs = 2'b01; pcw = (o == 6'd4 && z) || (o == 6'd5 && l); end
      4'd11: begin pcw = 1'b1; pcs = 2'b10; end
      4'd12: ill = 1'b1;
      default: ;
    endcase
    return {pcw, irw, rw, mr, mwr, io, rd, m2r, asa, asb, pcs, a1, a2, ill, be};
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  // One cycle: drive mem_ready, queue what the DUT must show this cycle, advance.
  task automatic cyc(input logic [3:0] st, input logic rdy, input logic x);
    exp_t e;
    mem_ready = rdy;
    e.st   = st;
    e.ctrl = exp_ctrl(st, op, zero, lt, rdy, x, exp_berr);
    e.cnt  = exp_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Full instruction: fw fetch stalls, mw memory stalls; retires into the next FETCH.
  task automatic run_instr(input logic [5:0] o, input logic z, input logic l,
                           input int fw, input int mw);
    op   = o;
    zero = z;
    lt   = l;
    repeat (fw) cyc(4'd0, 1'b0, 1'b0);
    cyc(4'd0, 1'b1, 1'b0);
    cyc(4'd1, rnd1(), 1'b0);
    case (o)
      6'd0:        begin cyc(4'd6, rnd1(), 1'b0); cyc(4'd7, rnd1(), 1'b0); end
      6'd2:        cyc(4'd11, rnd1(), 1'b0);
      6'd4, 6'd5:  cyc(4'd10, rnd1(), 1'b0);
      6'd8, 6'd9:  begin cyc(4'd8, rnd1(), 1'b0); cyc(4'd9, rnd1(), 1'b0); end
      6'd35: begin
        cyc(4'd2, rnd1(), 1'b0);
        repeat (mw) cyc(4'd3, 1'b0, 1'b0);
        cyc(4'd3, 1'b1, 1'b0);
        cyc(4'd4, rnd1(), 1'b0);
      end
      6'd43: begin
        cyc(4'd2, rnd1(), 1'b0);
        repeat (mw) cyc(4'd5, 1'b0, 1'b0);
        cyc(4'd5, 1'b1, 1'b0);
      end
      default: ;
    endcase
    exp_cnt = exp_cnt + 1'b1;
  endtask

  // Called just after a rising edge with the scoreboard drained.
  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b0;
    #1;
    exp_cnt  = '0;
    exp_berr = 1'b0;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctrl", 32'(ctrl_vec), 32'(exp_ctrl(4'd0, op, zero, lt, 1'b0, 1'b0, 1'b0)));
    check("rst_cnt", 32'(instr_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      check("state", 32'(state), 32'(mon_e.st));
      check("ctrl", 32'(ctrl_vec), 32'(mon_e.ctrl));
      check("count", 32'(instr_count), 32'(mon_e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ops [8];
    ops = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd9, 6'd35, 6'd43};
    reset     = 1'b1;
    op        = 6'd0;
    zero      = 1'b0;
    lt        = 1'b0;
    mem_ready = 1'b0;
    exp_cnt   = '0;
    exp_berr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Directed instructions with zero-wait and stalled memory.
    run_instr(6'd0, 1'b0, 1'b0, 0, 0);   // R: 0,1,6,7
    run_instr(6'd35, 1'b0, 1'b0, 0, 2);  // lw: 0,1,2,3,3,3,4
    run_instr(6'd4, 1'b1, 1'b0, 0, 0);   // beq taken
    run_instr(6'd4, 1'b0, 1'b1, 0, 0);   // beq not taken
    run_instr(6'd5, 1'b0, 1'b1, 0, 0);   // blt taken
    run_instr(6'd5, 1'b1, 1'b0, 0, 0);   // blt not taken
    run_instr(6'd9, 1'b0, 1'b0, 0, 0);   // subi
    run_instr(6'd8, 1'b0, 1'b0, 0, 0);   // addi
    run_instr(6'd2, 1'b0, 1'b0, 0, 0);   // j
    run_instr(6'd43, 1'b0, 1'b0, 0, 1);  // sw
    // One stall short of the watchdog in both FETCH and MEMRD must not trap.
    run_instr(6'd35, 1'b0, 1'b0, MW - 1, MW - 1);
    run_instr(6'd43, 1'b0, 1'b0, MW - 1, MW - 1);

    // Random legal traffic; the 4-bit counter wraps along the way.
    for (int i = 0; i < 40; i++) begin
      run_instr(ops[$urandom_range(0, 7)], rnd1(), rnd1(),
                int'($urandom_range(0, MW - 1)), int'($urandom_range(0, MW - 1)));
    end

    // Unknown opcode parks in TRAP until reset.
    op = 6'd63;
    cyc(4'd0, 1'b1, 1'b0);
    cyc(4'd1, rnd1(), 1'b0);
    repeat (20) cyc(4'd12, rnd1(), 1'b0);
    do_reset();

    // Watchdog in FETCH.
    op = 6'd0;
    repeat (MW - 1) cyc(4'd0, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b1);
    exp_berr = 1'b1;
    repeat (5) cyc(4'd12, rnd1(), 1'b0);
    do_reset();

    // Watchdog on a stalled sw; nothing retires.
    op = 6'd43;
    cyc(4'd0, 1'b1, 1'b0);
    cyc(4'd1, rnd1(), 1'b0);
    cyc(4'd2, rnd1(), 1'b0);
    repeat (MW - 1) cyc(4'd5, 1'b0, 1'b0);
    cyc(4'd5, 1'b0, 1'b1);
    exp_berr = 1'b1;
    repeat (3) cyc(4'd12, rnd1(), 1'b0);
    do_reset();

    // Reset in the middle of a stalled lw aborts it and clears the count.
    run_instr(6'd0, 1'b0, 1'b0, 0, 0);
    op = 6'd35;
    cyc(4'd0, 1'b1, 1'b0);
    cyc(4'd1, rnd1(), 1'b0);
    cyc(4'd2, rnd1(), 1'b0);
    cyc(4'd3, 1'b0, 1'b0);
    do_reset();
    run_instr(6'd8, 1'b0, 1'b0, 0, 0);
    cyc(4'd0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
